// File: rtl/avsdpll_pkg.sv
// avsdpll_pkg
//   Shared types and default constants for the AVSD PLL lock detector.
//   state_t : lock detector FSM states (OFF, ACQ, MEAS, LOCKED)
//   DEF_*   : default parameter values for avsdpll_lock_detect
package avsdpll_pkg;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      ACQ    = 2'd1,
      MEAS   = 2'd2,
      LOCKED = 2'd3
   } state_t;

   localparam int unsigned DEF_MULT         = 8;
   localparam int unsigned DEF_TOL          = 1;
   localparam int unsigned DEF_LOCK_WINDOWS = 4;
   localparam int unsigned DEF_TIMEOUT      = 16;
   localparam int unsigned DEF_CNT_W        = 8;

endpackage

// File: rtl/avsdpll_ref_sync.sv
// avsdpll_ref_sync
//   Brings the asynchronous reference clock into the CLK domain with a
//   two-flop synchronizer and produces a one-cycle pulse per rising edge.
//   The pulse is visible after the second CLK edge following a REF rise and
//   is acted on by the consumer at the third edge.
// Ports
//   clk      in   sampling clock (PLL output)
//   rst_n    in   asynchronous active-low reset
//   ref_in   in   asynchronous reference clock, sampled as data
//   ref_edge out  one-cycle rising-edge pulse (CLK domain)
module avsdpll_ref_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic ref_in,
   output logic ref_edge
);

   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= ref_in;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign ref_edge = sync2 & ~prev;

endmodule

// File: rtl/avsdpll_lock_detect.sv
// avsdpll_lock_detect
//   Lock detector clocked by the PLL output. Counts CLK cycles between
//   synchronized REF rising edges and asserts lock after LOCK_WINDOWS
//   consecutive periods within MULT +/- TOL. Lock drops on a bad period or
//   when no REF edge arrives for TIMEOUT cycles.
//   Optional feature macro: AVSDPLL_LOCK_STICKY_EN enables the sticky
//   lock_err flag; without it lock_err is tied low and err_clr is ignored.
// Ports
//   CLK        in   PLL output clock, sole clock
//   reset_n    in   asynchronous active-low reset
//   EN_VCO     in   PLL enable; low forces the OFF state
//   REF        in   asynchronous reference clock
//   lock       out  PLL locked
//   period     out  last measured REF period in CLK cycles
//   period_vld out  one-cycle pulse when period updates
//   lock_lost  out  one-cycle pulse when lock falls (not on disable/reset)
//   err_clr    in   clears lock_err
//   lock_err   out  sticky loss-of-lock flag
module avsdpll_lock_detect
   import avsdpll_pkg::*;
#(
   parameter int unsigned MULT         = DEF_MULT,
   parameter int unsigned TOL          = DEF_TOL,
   parameter int unsigned LOCK_WINDOWS = DEF_LOCK_WINDOWS,
   parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
   parameter int unsigned CNT_W        = DEF_CNT_W
) (
   input  logic             CLK,
   input  logic             reset_n,
   input  logic             EN_VCO,
   input  logic             REF,
   output logic             lock,
   output logic [CNT_W-1:0] period,
   output logic             period_vld,
   output logic             lock_lost,
   input  logic             err_clr,
   output logic             lock_err
);

   localparam int unsigned GW = $clog2(LOCK_WINDOWS + 1);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] P_LO    = CNT_W'(MULT - TOL);
   localparam logic [CNT_W-1:0] P_HI    = CNT_W'(MULT + TOL);
   localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
   localparam logic [GW-1:0]    G_LAST  = GW'(LOCK_WINDOWS - 1);

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [GW-1:0]    gcnt;
   logic [GW-1:0]    gcnt_n;
   logic [CNT_W-1:0] period_n;
   logic             vld_n;
   logic             lost_n;
   logic             lock_n;

   logic             ref_edge;
   logic [CNT_W-1:0] meas;
   logic             good;
   logic             timeout_hit;

   avsdpll_ref_sync u_ref_sync (
      .clk      (CLK),
      .rst_n    (reset_n),
      .ref_in   (REF),
      .ref_edge (ref_edge)
   );

   // Period ends on the edge cycle itself, hence +1; a saturated count stays
   // saturated so it can never wrap into the good window.
   assign meas        = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
   assign good        = (meas >= P_LO) && (meas <= P_HI);
   assign timeout_hit = (cnt == TMO);

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state      <= OFF;
         cnt        <= '0;
         gcnt       <= '0;
         period     <= '0;
         period_vld <= 1'b0;
         lock_lost  <= 1'b0;
         lock       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         gcnt       <= gcnt_n;
         period     <= period_n;
         period_vld <= vld_n;
         lock_lost  <= lost_n;
         lock       <= lock_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      gcnt_n   = gcnt;
      period_n = period;
      vld_n    = 1'b0;
      lost_n   = 1'b0;

      if (ref_edge) begin
         cnt_n = '0;
      end

      case (state)
         OFF: begin
            cnt_n  = '0;
            gcnt_n = '0;
            state_n = ACQ;
         end
         ACQ: begin
            // The first edge only starts the period count.
            gcnt_n = '0;
            if (ref_edge) begin
               state_n = MEAS;
            end
         end
         MEAS: begin
            // An edge takes priority over a coincident timeout.
            if (ref_edge) begin
               period_n = meas;
               vld_n    = 1'b1;
               if (good) begin
                  if (gcnt == G_LAST) begin
                     state_n = LOCKED;
                     gcnt_n  = '0;
                  end else begin
                     gcnt_n = gcnt + 1'b1;
                  end
               end else begin
                  gcnt_n = '0;
               end
            end else if (timeout_hit) begin
               state_n = ACQ;
               gcnt_n  = '0;
            end
         end
         LOCKED: begin
            if (ref_edge) begin
               period_n = meas;
               vld_n    = 1'b1;
               if (!good) begin
                  state_n = MEAS;
                  gcnt_n  = '0;
                  lost_n  = 1'b1;
               end
            end else if (timeout_hit) begin
               state_n = ACQ;
               gcnt_n  = '0;
               lost_n  = 1'b1;
            end
         end
         default: begin
            state_n = OFF;
         end
      endcase

      // Disable overrides everything and is silent: no pulses, no loss report.
      if (!EN_VCO) begin
         state_n  = OFF;
         cnt_n    = '0;
         gcnt_n   = '0;
         period_n = period;
         vld_n    = 1'b0;
         lost_n   = 1'b0;
      end
   end

   assign lock_n = (state_n == LOCKED);

`ifdef AVSDPLL_LOCK_STICKY_EN
   // Set has priority over clear when both happen in the same cycle.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         lock_err <= 1'b0;
      end else if (lock_lost) begin
         lock_err <= 1'b1;
      end else if (err_clr) begin
         lock_err <= 1'b0;
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign lock_err       = 1'b0;
`endif

endmodule

// File: tb/tb_avsdpll_lock_detect.sv
module tb_avsdpll_lock_detect;

   localparam int MULT = 8;
   localparam int TOL  = 1;
   localparam int LW   = 4;
   localparam int TMO  = 16;
   localparam int CW   = 8;

   logic          CLK     = 1'b0;
   logic          reset_n = 1'b0;
   logic          EN_VCO  = 1'b0;
   logic          REF     = 1'b0;
   logic          err_clr = 1'b0;
   logic          lock;
   logic [CW-1:0] period;
   logic          period_vld;
   logic          lock_lost;
   logic          lock_err;

   avsdpll_lock_detect #(
      .MULT(MULT), .TOL(TOL), .LOCK_WINDOWS(LW), .TIMEOUT(TMO), .CNT_W(CW)
   ) dut (
      .CLK        (CLK),
      .reset_n    (reset_n),
      .EN_VCO     (EN_VCO),
      .REF        (REF),
      .lock       (lock),
      .period     (period),
      .period_vld (period_vld),
      .lock_lost  (lock_lost),
      .err_clr    (err_clr),
      .lock_err   (lock_err)
   );

   always #5 CLK = ~CLK;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: tracks the cycle index of the last accepted REF edge,
   // a run length of good periods, and whether measurement is armed/locked.
   int  k;
   bit  m_on, m_armed, m_locked, m_vld, m_lost, m_err;
   int  m_streak, m_last, m_period;
   bit  ref_q[$];
   int  dut_lost_cnt, mdl_lost_cnt;
   bit  clr_rand;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      k = 0; m_on = 0; m_armed = 0; m_locked = 0; m_vld = 0; m_lost = 0; m_err = 0;
      m_streak = 0; m_last = 0; m_period = 0;
      ref_q = {1'b0, 1'b0, 1'b0, 1'b0};
   endtask

   // One active clock edge of the specified behaviour.
   task automatic model_edge();
      bit edge_seen;
      bit prev_lost;
      int p;
      prev_lost = m_lost;
      k++;
      ref_q.push_back(REF);
      if (ref_q.size() > 6) void'(ref_q.pop_front());
      // REF sampled two edges ago is high and three edges ago was low.
      edge_seen = ref_q[ref_q.size()-3] && !ref_q[ref_q.size()-4];
      m_vld  = 0;
      m_lost = 0;
      if (!EN_VCO) begin
         m_on = 0; m_armed = 0; m_locked = 0; m_streak = 0;
      end else if (!m_on) begin
         m_on = 1;
      end else if (!m_armed) begin
         if (edge_seen) begin
            m_armed = 1;
            m_last  = k;
         end
      end else if (edge_seen) begin
         p = k - m_last;
         if (p > 255) p = 255;
         m_period = p;
         m_vld    = 1;
         m_last   = k;
         if (p >= MULT - TOL && p <= MULT + TOL) begin
            if (!m_locked) begin
               m_streak++;
               if (m_streak == LW) begin
                  m_locked = 1;
                  m_streak = 0;
               end
            end
         end else begin
            if (m_locked) m_lost = 1;
            m_locked = 0;
            m_streak = 0;
         end
      end else if (k - 1 - m_last == TMO) begin
         if (m_locked) m_lost = 1;
         m_armed = 0; m_locked = 0; m_streak = 0;
      end
`ifdef AVSDPLL_LOCK_STICKY_EN
      if (prev_lost) m_err = 1;
      else if (err_clr) m_err = 0;
`else
      m_err = 0;
`endif
   endtask

   task automatic step(input bit en, input bit r);
      @(negedge CLK);
      EN_VCO  = en;
      REF     = r;
      err_clr = clr_rand ? ($urandom_range(0, 7) == 0) : 1'b0;
      @(posedge CLK);
      model_edge();
      #1;
      chk("lock",       lock,       m_locked);
      chk("period",     period,     m_period & 255);
      chk("period_vld", period_vld, m_vld);
      chk("lock_lost",  lock_lost,  m_lost);
      chk("lock_err",   lock_err,   m_err);
      if (lock_lost) dut_lost_cnt++;
      if (m_lost)    mdl_lost_cnt++;
   endtask

   task automatic run_period(input int p);
      int hi;
      hi = (p / 2 < 1) ? 1 : p / 2;
      for (int i = 0; i < p; i++) step(1'b1, (i < hi));
   endtask

   task automatic run_list(input int ps[$]);
      foreach (ps[i]) run_period(ps[i]);
   endtask

   initial begin
      int lost0;
      int choice;
      int plist[10] = '{5, 6, 7, 8, 8, 9, 10, 16, 17, 18};
      clr_rand = 0;
      dut_lost_cnt = 0;
      mdl_lost_cnt = 0;
      model_reset();

      // Reset values.
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_lock", lock, 0);
      chk("rst_period", period, 0);
      chk("rst_vld", period_vld, 0);
      chk("rst_lost", lock_lost, 0);
      chk("rst_err", lock_err, 0);
      @(negedge CLK);
      reset_n = 1'b1;

      // Nominal 8-cycle REF: arm + 4 good edges -> lock.
      repeat (3) step(1'b1, 1'b0);
      repeat (4) run_period(8);
      chk("pin_nolock_after_4_edges", lock, 0);
      chk("pin_period_8", period, 8);
      run_period(8);
      chk("pin_lock_after_5_edges", lock, 1);
      chk("pin_model_locked", m_locked, 1);

      // One long period while locked -> lock_lost, then relock after 4 good.
      lost0 = dut_lost_cnt;
      run_period(11);
      run_period(8);
      chk("pin_lock_dropped", lock, 0);
      chk("pin_lost_one_pulse", dut_lost_cnt - lost0, 1);
      chk("pin_period_11", period, 11);
      repeat (3) run_period(8);
      chk("pin_relock_pending", lock, 0);
      run_period(8);
      chk("pin_relocked", lock, 1);

      // Periods 6/10 break the streak; 7/9 count as good.
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      run_list('{8, 8, 8, 6, 8, 8, 8, 10, 8, 8, 8, 6, 8});
      chk("pin_no_lock_6_10", lock, 0);
      run_list('{7, 9, 7});
      chk("pin_79_pending", lock, 0);
      run_period(9);
      chk("pin_lock_79", lock, 1);
      run_period(7);

      // REF stops while locked -> timeout drops lock, back to acquisition.
      lost0 = dut_lost_cnt;
      repeat (25) step(1'b1, 1'b0);
      chk("pin_timeout_unlock", lock, 0);
      chk("pin_timeout_lost", dut_lost_cnt - lost0, 1);
      chk("pin_model_disarmed", m_armed, 0);

      // Disable mid-measurement (three good periods counted): silent drop.
      repeat (4) run_period(8);
      lost0 = dut_lost_cnt;
      step(1'b0, 1'b0);
      chk("pin_dis_lock", lock, 0);
      chk("pin_dis_nolost", dut_lost_cnt - lost0, 0);
      step(1'b1, 1'b0);
      repeat (4) run_period(8);
      chk("pin_reen_pending", lock, 0);
      run_period(8);
      chk("pin_reen_lock", lock, 1);

      // Asynchronous reset while locked.
      @(negedge CLK);
      reset_n = 1'b0;
      REF     = 1'b0;
      EN_VCO  = 1'b0;
      #1;
      chk("arst_lock", lock, 0);
      chk("arst_period", period, 0);
      chk("arst_lost", lock_lost, 0);
      model_reset();
      repeat (2) @(negedge CLK);
      reset_n = 1'b1;
      step(1'b1, 1'b0);

      // Randomized periods, gaps, disables and error clears.
      clr_rand = 1;
      for (int n = 0; n < 250; n++) begin
         choice = $urandom_range(0, 19);
         if (choice == 0) begin
            repeat ($urandom_range(1, 3)) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
         end else if (choice == 1) begin
            repeat (20) step(1'b1, 1'b0);
         end else if (choice < 8) begin
            run_period(plist[$urandom_range(0, 9)]);
         end else begin
            run_period($urandom_range(MULT - TOL, MULT + TOL));
         end
      end
      chk("lost_count_total", dut_lost_cnt, mdl_lost_cnt);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
